// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared defaults for the GF(2^M) adder/accumulator.
//   GF_M    default field degree / operand width
//   GF_CW   default width of the saturating term counter
//   gf_state_e  controller state encoding (IDLE / ACC / HOLD)
//   CNT_MAX saturation value of the counter at the default width
package gf2m_pkg;

  localparam int unsigned GF_M  = 163;
  localparam int unsigned GF_CW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } gf_state_e;

  // Largest count representable in a cw-bit counter.
  function automatic int unsigned gf_cnt_max(input int unsigned cw);
    return (32'd1 << cw) - 32'd1;
  endfunction

  localparam int unsigned CNT_MAX = gf_cnt_max(GF_CW);

endpackage

// File: rtl/gf2m_xor.sv
// gf2m_xor: combinational GF(2^M) addition (bitwise XOR, no carries).
// Ports:
//   i_add_a  in  M  operand A
//   i_add_b  in  M  operand B
//   o_add_r  out M  A ^ B
module gf2m_xor
  import gf2m_pkg::*;
#(
  parameter int unsigned M = GF_M
) (
  input  logic [M-1:0] i_add_a,
  input  logic [M-1:0] i_add_b,
  output logic [M-1:0] o_add_r
);

  assign o_add_r = i_add_a ^ i_add_b;

endmodule

// File: rtl/gf2m_add_acc.sv
// gf2m_add_acc: GF(2^M) adder / accumulator with valid/ready streaming.
// Pairwise mode emits A^B per beat; accumulate mode XOR-folds a burst of
// operand pairs (terminated by i_in_last) into a single registered result.
// Optional macro: GF_ADD_ZERO_FLAG_EN adds o_out_zero (result == 0 flag).
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous reset, active-high
//   i_clr        synchronous abort of the open burst (below i_rst)
//   i_mode       0 = pairwise, 1 = accumulate (sampled on a burst's first beat)
//   i_in_valid   operand beat valid
//   o_in_ready   beat can be accepted this cycle
//   i_in_last    last beat of an accumulate burst
//   i_add_a/b    operands (M bits)
//   o_out_valid  result valid
//   i_out_ready  downstream accepts result
//   o_out_data   GF(2^M) sum (M bits)
//   o_out_cnt    operand pairs folded into o_out_data (CW bits, saturating)
//   o_out_sat    counter saturated during this burst
//   o_out_zero   (GF_ADD_ZERO_FLAG_EN only) o_out_data == 0
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | no burst open, no result pending
// ACC     | burst open, r_acc holds partial sum
// HOLD    | result pending on output (o_out_valid = 1)
module gf2m_add_acc
  import gf2m_pkg::*;
#(
  parameter int unsigned M  = GF_M,
  parameter int unsigned CW = GF_CW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_mode,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic          i_in_last,
  input  logic [M-1:0]  i_add_a,
  input  logic [M-1:0]  i_add_b,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [M-1:0]  o_out_data,
  output logic [CW-1:0] o_out_cnt,
  output logic          o_out_sat
`ifdef GF_ADD_ZERO_FLAG_EN
  ,output logic         o_out_zero
`endif
);

  localparam logic [CW-1:0] L_CNT_MAX = '1;
  localparam logic [CW-1:0] L_CNT_ONE = CW'(1);

  gf_state_e     r_state, w_state_nxt;
  logic [M-1:0]  r_acc, w_acc_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_sat, w_sat_nxt;
  logic          r_out_valid, w_ov_nxt;
  logic [M-1:0]  r_out_data, w_od_nxt;
  logic [CW-1:0] r_out_cnt, w_oc_nxt;
  logic          r_out_sat, w_os_nxt;

  logic [M-1:0]  w_term;
  logic [M-1:0]  w_fold;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_cnt_blk;
  logic [CW-1:0] w_cnt_inc;

  gf2m_xor #(.M(M)) u_xor_term (
    .i_add_a (i_add_a),
    .i_add_b (i_add_b),
    .o_add_r (w_term)
  );

  gf2m_xor #(.M(M)) u_xor_fold (
    .i_add_a (r_acc),
    .i_add_b (w_term),
    .o_add_r (w_fold)
  );

  // The output stage is a single register: a beat may enter whenever that
  // register is empty or is being drained in the same cycle. ACC is only
  // reachable with the output empty, so non-last burst beats never stall.
  assign w_in_ready = !i_clr && (!r_out_valid || i_out_ready);
  assign w_accept   = i_in_valid && w_in_ready;

  assign w_cnt_blk  = (r_cnt == L_CNT_MAX);
  assign w_cnt_inc  = w_cnt_blk ? r_cnt : (r_cnt + L_CNT_ONE);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_sat_nxt   = r_sat;
    w_ov_nxt    = r_out_valid;
    w_od_nxt    = r_out_data;
    w_oc_nxt    = r_out_cnt;
    w_os_nxt    = r_out_sat;

    if (r_out_valid && i_out_ready) begin
      w_ov_nxt = 1'b0;
    end

    if (i_clr) begin
      // Abort only the partial burst; a pending result still drains normally.
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_sat_nxt   = 1'b0;
      w_state_nxt = w_ov_nxt ? ST_HOLD : ST_IDLE;
    end else if (w_accept) begin
      if (r_state == ST_ACC) begin
        if (i_in_last) begin
          w_od_nxt    = w_fold;
          w_oc_nxt    = w_cnt_inc;
          w_os_nxt    = r_sat || w_cnt_blk;
          w_ov_nxt    = 1'b1;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_sat_nxt   = 1'b0;
          w_state_nxt = ST_HOLD;
        end else begin
          w_acc_nxt = w_fold;
          w_cnt_nxt = w_cnt_inc;
          w_sat_nxt = r_sat || w_cnt_blk;
        end
      end else begin
        // First beat of a burst: the only place i_mode is looked at.
        if (!i_mode || i_in_last) begin
          w_od_nxt    = w_term;
          w_oc_nxt    = L_CNT_ONE;
          w_os_nxt    = 1'b0;
          w_ov_nxt    = 1'b1;
          w_state_nxt = ST_HOLD;
        end else begin
          w_acc_nxt   = w_term;
          w_cnt_nxt   = L_CNT_ONE;
          w_sat_nxt   = 1'b0;
          w_state_nxt = ST_ACC;
        end
      end
    end else if ((r_state == ST_HOLD) && !w_ov_nxt) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cnt   <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sat       <= w_sat_nxt;
      r_out_valid <= w_ov_nxt;
      r_out_data  <= w_od_nxt;
      r_out_cnt   <= w_oc_nxt;
      r_out_sat   <= w_os_nxt;
    end
  end

`ifdef GF_ADD_ZERO_FLAG_EN
  logic r_out_zero;

  // Updated only when a new result is loaded so the flag stays 0 out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_zero <= 1'b0;
    end else if (w_ov_nxt && (!r_out_valid || i_out_ready)) begin
      r_out_zero <= (w_od_nxt == '0);
    end
  end

  assign o_out_zero = r_out_zero;
`endif

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_cnt   = r_out_cnt;
  assign o_out_sat   = r_out_sat;

endmodule

// File: tb/tb_gf2m_add_acc.sv
module tb_gf2m_add_acc;

  localparam int unsigned M = 163;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         mode;
  logic         in_valid;
  logic         in_last;
  logic         out_ready;
  logic [M-1:0] add_a;
  logic [M-1:0] add_b;

  logic         in_ready, ov, os;
  logic [M-1:0] od;
  logic [7:0]   oc;

  logic         in_ready2, ov2, os2;
  logic [M-1:0] od2;
  logic [1:0]   oc2;

`ifdef GF_ADD_ZERO_FLAG_EN
  logic oz, oz2;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [M-1:0] d;
    logic [7:0]   c;
    logic         s;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon_e;

  logic         m_open;
  logic [M-1:0] m_acc;
  int           m_cnt;
  logic         m_sat;

  gf2m_add_acc #(.M(M), .CW(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clr       (clr),
    .i_mode      (mode),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_last   (in_last),
    .i_add_a     (add_a),
    .i_add_b     (add_b),
    .o_out_valid (ov),
    .i_out_ready (out_ready),
    .o_out_data  (od),
    .o_out_cnt   (oc),
    .o_out_sat   (os)
`ifdef GF_ADD_ZERO_FLAG_EN
    ,.o_out_zero (oz)
`endif
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  gf2m_add_acc #(.M(M), .CW(2)) dut_sat (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clr       (clr),
    .i_mode      (mode),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready2),
    .i_in_last   (in_last),
    .i_add_a     (add_a),
    .i_add_b     (add_b),
    .o_out_valid (ov2),
    .i_out_ready (out_ready),
    .o_out_data  (od2),
    .o_out_cnt   (oc2),
    .o_out_sat   (os2)
`ifdef GF_ADD_ZERO_FLAG_EN
    ,.o_out_zero (oz2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (!rst && ov && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got data=%0h cnt=%0d, required no output", od, oc);
      end else begin
        mon_e = sbq.pop_front();
        if ({od, oc, os} !== {mon_e.d, mon_e.c, mon_e.s}) begin
          errors++;
          $display("FAIL sb_result: got data=%0h cnt=%0d sat=%0b, required data=%0h cnt=%0d sat=%0b",
                   od, oc, os, mon_e.d, mon_e.c, mon_e.s);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one beat, wait (bounded) for acceptance, then update the model.
  task automatic send(input logic [M-1:0] a, input logic [M-1:0] b,
                      input logic last, input logic md);
    int n;
    logic [M-1:0] t;
    add_a    = a;
    add_b    = b;
    in_last  = last;
    mode     = md;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (n < 50) begin
      t = a ^ b;
      if (!m_open) begin
        if (!md || last) begin
          sbq.push_back('{d: t, c: 8'd1, s: 1'b0});
        end else begin
          m_open = 1'b1;
          m_acc  = t;
          m_cnt  = 1;
          m_sat  = 1'b0;
        end
      end else begin
        m_acc = m_acc ^ t;
        if (m_cnt == 255) m_sat = 1'b1;
        else m_cnt++;
        if (last) begin
          sbq.push_back('{d: m_acc, c: m_cnt[7:0], s: m_sat});
          m_open = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; mode = 1'b0; add_a = 'h5; add_b = 'h9;
    idle(3);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ov, od, oc, os} !== {1'b0, {M{1'b0}}, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b d=%0h c=%0d s=%0b, required all 0", ov, od, oc, os);
    end
    checks++;
    if (in_ready !== 1'b1 || ov2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got in_ready=%0b v2=%0b, required 1 0", in_ready, ov2);
    end
`ifdef GF_ADD_ZERO_FLAG_EN
    checks++;
    if (oz !== 1'b0) begin
      errors++;
      $display("FAIL reset_zero: got %0b, required 0", oz);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_pairwise();
    send('h5, 'h3, 1'b0, 1'b0);
    checks++;
    if (ov !== 1'b1 || od !== M'('h6) || oc !== 8'd1) begin
      errors++;
      $display("FAIL pairwise: got v=%0b d=%0h c=%0d, required 1 6 1", ov, od, oc);
    end
  endtask

  task automatic test_burst();
    send('h1, 'h2, 1'b0, 1'b1);
    checks++;
    if (ov !== 1'b0) begin
      errors++;
      $display("FAIL burst_mid_valid: got %0b, required 0", ov);
    end
    send('h4, 'h0, 1'b0, 1'b0);
    send('h8, 'h8, 1'b1, 1'b0);
    checks++;
    if (ov !== 1'b1 || od !== M'('h7) || oc !== 8'd3) begin
      errors++;
      $display("FAIL burst_result: got v=%0b d=%0h c=%0d, required 1 7 3", ov, od, oc);
    end
  endtask

  task automatic test_backpressure();
    idle(1);
    out_ready = 1'b0;
    send('h1, 'h2, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || ov !== 1'b1 || od !== M'('h3) || oc !== 8'd1) begin
        errors++;
        $display("FAIL bp_hold: got rdy=%0b v=%0b d=%0h c=%0d, required 0 1 3 1", in_ready, ov, od, oc);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send('h4, 'h1, 1'b0, 1'b0);
    checks++;
    if (ov !== 1'b1 || od !== M'('h5)) begin
      errors++;
      $display("FAIL bp_no_bubble: got v=%0b d=%0h, required 1 5", ov, od);
    end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 5; i++) begin
      send(M'(i), 'h0, (i == 5), 1'b1);
    end
    checks++;
    if (ov2 !== 1'b1 || od2 !== M'('h1) || oc2 !== 2'd3 || os2 !== 1'b1) begin
      errors++;
      $display("FAIL sat_burst: got v=%0b d=%0h c=%0d s=%0b, required 1 1 3 1", ov2, od2, oc2, os2);
    end
    send('h6, 'h0, 1'b0, 1'b1);
    send('h1, 'h0, 1'b1, 1'b1);
    checks++;
    if (ov2 !== 1'b1 || od2 !== M'('h7) || oc2 !== 2'd2 || os2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_cleared: got v=%0b d=%0h c=%0d s=%0b, required 1 7 2 0", ov2, od2, oc2, os2);
    end
  endtask

  task automatic test_clr_rst();
    send('h3, 'h0, 1'b0, 1'b1);
    send('h5, 'h0, 1'b0, 1'b1);
    clr = 1'b1; in_valid = 1'b1; in_last = 1'b1; mode = 1'b1; add_a = 'hAA; add_b = 'h0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_ready: got %0b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    m_open = 1'b0;
    @(negedge clk);
    checks++;
    if (ov !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_output: got %0b, required 0", ov);
    end
    @(posedge clk);
    #1;
    send('hF, 'h0, 1'b1, 1'b1);
    checks++;
    if (ov !== 1'b1 || od !== M'('hF) || oc !== 8'd1) begin
      errors++;
      $display("FAIL clr_next_burst: got v=%0b d=%0h c=%0d, required 1 f 1", ov, od, oc);
    end
    idle(1);
    send('h1, 'h1, 1'b0, 1'b1);
    send('h2, 'h0, 1'b0, 1'b1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    m_open = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ov !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_output: got %0b, required 0", ov);
      end
    end
    @(posedge clk);
    #1;
    send('h6, 'h0, 1'b1, 1'b1);
  endtask

  task automatic test_zero();
    logic [M-1:0] ones;
    ones = '1;
    send(ones, ones, 1'b0, 1'b0);
    checks++;
    if (od !== {M{1'b0}}) begin
      errors++;
      $display("FAIL zero_data: got %0h, required 0", od);
    end
`ifdef GF_ADD_ZERO_FLAG_EN
    checks++;
    if (oz !== 1'b1) begin
      errors++;
      $display("FAIL zero_flag_set: got %0b, required 1", oz);
    end
`endif
    send('h1, 'h0, 1'b0, 1'b0);
`ifdef GF_ADD_ZERO_FLAG_EN
    checks++;
    if (oz !== 1'b0) begin
      errors++;
      $display("FAIL zero_flag_clr: got %0b, required 0", oz);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [191:0] ra, rb;
    int len;
    logic md;
    for (int k = 0; k < 20; k++) begin
      md  = 1'($urandom_range(0, 1));
      len = md ? $urandom_range(1, 4) : 1;
      for (int j = 0; j < len; j++) begin
        ra = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        rb = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        send(ra[M-1:0], rb[M-1:0], (j == len - 1), (j == 0) ? md : ~md);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; add_a = '0; add_b = '0;
    m_open = 1'b0; m_acc = '0; m_cnt = 0; m_sat = 1'b0;
    test_reset();
    test_pairwise();
    test_burst();
    test_backpressure();
    test_saturation();
    test_clr_rst();
    test_zero();
    test_back_to_back();
    idle(4);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d results outstanding, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
